// File: rtl/greenrio_bus_pkg.sv
// Shared types and constants for the greenrio Wishbone host bridge.
// The bridge waits without limit unless GREENRIO_WB_TIMEOUT_EN is defined.
package greenrio_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT,
    S_DRAIN,
    S_ACK
  } state_t;

  localparam logic [31:0] GR_ADDR_BASE = 32'h3000_0000;
  localparam logic [31:0] GR_ADDR_MASK = 32'hFFF0_0000;
  localparam logic [31:0] GR_ERR_DATA  = 32'hDEAD_0BAD;
  localparam int GR_TIMEOUT_CYCLES = 255;
  localparam int GR_TW = 8;

  function automatic logic [31:0] word_off(
    input logic [31:0] adr,
    input logic [31:0] mask
  );
    return adr & ~mask & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/greenrio_wb_timeout.sv
// Wait-cycle counter for the host bridge; expires on the LIMIT-th
// enabled cycle since the last clear.
module greenrio_wb_timeout #(
  parameter int TW    = 8,
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == TW'(LIMIT - 1));

endmodule

// File: rtl/greenrio_wb_host_bridge.sv
// Wishbone-classic slave to greenrio req/gnt/rvalid bus bridge.
// Define GREENRIO_WB_TIMEOUT_EN to abandon hung gnt/rvalid waits.
module greenrio_wb_host_bridge
  import greenrio_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = GR_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK      = GR_ADDR_MASK,
  parameter int          TIMEOUT_CYCLES = GR_TIMEOUT_CYCLES,
  parameter int          TW             = GR_TW,
  parameter logic [31:0] ERR_DATA       = GR_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  state_t      r_state, w_next;
  logic [31:0] r_dat, w_dat_nxt;
  logic        r_err, w_err_set;
  logic        w_load, w_hit, w_expire;

  assign w_hit = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;

`ifdef GREENRIO_WB_TIMEOUT_EN
  logic w_tmo_en, w_tmo_clr;

  assign w_tmo_en  = (r_state == S_REQ) || (r_state == S_RDWAIT) ||
                     (r_state == S_DRAIN);
  assign w_tmo_clr = (w_next != r_state);

  greenrio_wb_timeout #(
    .TW   (TW),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_clr   (w_tmo_clr),
    .i_en    (w_tmo_en),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    w_dat_nxt = r_dat;
    unique case (r_state)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (w_hit) begin
            w_next = S_REQ;
            w_load = 1'b1;
          end else begin
            w_next    = S_ACK;
            w_err_set = 1'b1;
            if (!wbs_we_i) w_dat_nxt = ERR_DATA;
          end
        end
      end
      S_REQ: begin
        // An accepted request must run to completion even if cyc drops.
        if (mem_gnt_i) begin
          if (mem_we_o) w_next = wbs_cyc_i ? S_ACK : S_IDLE;
          else          w_next = wbs_cyc_i ? S_RDWAIT : S_DRAIN;
        end else if (!wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (w_expire) begin
          w_next    = S_ACK;
          w_err_set = 1'b1;
          w_dat_nxt = ERR_DATA;
        end
      end
      S_RDWAIT: begin
        if (mem_rvalid_i) begin
          w_next    = S_ACK;
          w_dat_nxt = mem_rdata_i;
        end else if (!wbs_cyc_i) begin
          w_next = S_DRAIN;
        end else if (w_expire) begin
          w_next    = S_ACK;
          w_err_set = 1'b1;
          w_dat_nxt = ERR_DATA;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid_i) begin
          w_next = S_IDLE;
        end else if (w_expire) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_dat       <= '0;
      r_err       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      r_state <= w_next;
      r_dat   <= w_dat_nxt;
      r_err   <= w_err_set;
      if (w_load) begin
        mem_we_o    <= wbs_we_i;
        mem_addr_o  <= word_off(wbs_adr_i, ADDR_MASK);
        mem_be_o    <= wbs_sel_i;
        mem_wdata_o <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o = (r_state == S_ACK);
  assign wbs_dat_o = r_dat;
  assign mem_req_o = (r_state == S_REQ);
  assign busy_o    = (r_state != S_IDLE);
  assign err_o     = r_err;

endmodule
